// File: rtl/cnn_pkg.sv
// cnn_pkg: shared layer dimensions and iterator FSM state encoding
package cnn_pkg;
  localparam int K_DEF = 5;
  localparam int OUT_SIZE_DEF = 28;
  localparam int IN_CHANNEL_DEF = 1;
  localparam int OUT_CHANNEL_DEF = 6;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
endpackage

// File: rtl/wrap_counter.sv
// wrap_counter: one loop level; steps by STEP when enabled and wraps to 0 after LIMIT
module wrap_counter import cnn_pkg::*; #(
  parameter int W = 8,
  parameter int LIMIT = 0,
  parameter int STEP = 1
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] value,
  output logic         carry
);
  // carry flags the terminal count; the parent ANDs it into the next level's enable
  assign carry = value == W'(LIMIT);
  // clear has priority so a new layer always starts from zero
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) value <= '0;
    else if (clear) value <= '0;
    else if (en) value <= carry ? '0 : value + W'(STEP);
endmodule

// File: rtl/loop_iterator.sv
// loop_iterator: walks the m,r,c,n,i,j convolution loop nest one accepted tuple per cycle
module loop_iterator import cnn_pkg::*; #(
  parameter int K = K_DEF,
  parameter int OUT_SIZE = OUT_SIZE_DEF,
  parameter int IN_CHANNEL = IN_CHANNEL_DEF,
  parameter int OUT_CHANNEL = OUT_CHANNEL_DEF
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       start,
  input  logic       ready,
  output logic [7:0] m,
  output logic [7:0] r,
  output logic [7:0] c,
  output logic [7:0] n,
  output logic [3:0] i,
  output logic [3:0] j,
  output logic       valid,
  output logic       tap_first,
  output logic       tap_last,
  output logic       busy,
  output logic       done
);
  logic [1:0] state;
  logic tj, ti, tn, tc, tr, tm, all_max, advance, step, clear;
  assign advance = state == RUN && ready;
  assign all_max = tj && ti && tn && tc && tr && tm;
  // the final tuple is not stepped past, so the outputs keep it through DONE
  assign step = advance && !all_max;
  assign clear = state == IDLE && start;
  assign valid = state == RUN;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign tap_first = valid && n == 8'd0 && i == 4'd0 && j == 4'd0;
  assign tap_last = valid && tn && ti && tj;
  wrap_counter #(.W(4), .LIMIT(K - 1)) u_j (
    .clock(clock), .rst_n(rst_n), .clear(clear), .en(step), .value(j), .carry(tj));
  wrap_counter #(.W(4), .LIMIT(K - 1)) u_i (
    .clock(clock), .rst_n(rst_n), .clear(clear), .en(step && tj), .value(i), .carry(ti));
  wrap_counter #(.W(8), .LIMIT(4 * (IN_CHANNEL - 1)), .STEP(4)) u_n (
    .clock(clock), .rst_n(rst_n), .clear(clear), .en(step && tj && ti), .value(n), .carry(tn));
  wrap_counter #(.W(8), .LIMIT(OUT_SIZE - 1)) u_c (
    .clock(clock), .rst_n(rst_n), .clear(clear), .en(step && tj && ti && tn), .value(c), .carry(tc));
  wrap_counter #(.W(8), .LIMIT(OUT_SIZE - 1)) u_r (
    .clock(clock), .rst_n(rst_n), .clear(clear), .en(step && tj && ti && tn && tc), .value(r), .carry(tr));
  wrap_counter #(.W(8), .LIMIT(OUT_CHANNEL - 1)) u_m (
    .clock(clock), .rst_n(rst_n), .clear(clear), .en(step && tj && ti && tn && tc && tr), .value(m), .carry(tm));
  // IDLE waits for start, RUN ends on the accepted final tuple, DONE lasts one cycle
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state == IDLE ? (start ? RUN : IDLE) :
                  state == RUN ? (advance && all_max ? DONE : RUN) : IDLE;
endmodule

// File: doc/loop_iterator.md
LOOP_ITERATOR -- requirements
Module: loop_iterator

Interface
REQ-001 The block SHALL provide parameter K, default 5, kernel size; i and j span 0..K-1.
REQ-002 The block SHALL provide parameter OUT_SIZE, default 28, output feature-map side; r and c span 0..OUT_SIZE-1.
REQ-003 The block SHALL provide parameter IN_CHANNEL, default 1, input channel groups; n spans 0, 4, .., 4*(IN_CHANNEL-1).
REQ-004 The block SHALL provide parameter OUT_CHANNEL, default 6, output channels; m spans 0..OUT_CHANNEL-1.
REQ-005 The block SHALL have port clock, input, 1 bit, sole clock; rising edge active.
REQ-006 The block SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-007 The block SHALL have port start, input, 1 bit, single-cycle request to begin a layer.
REQ-008 The block SHALL have port ready, input, 1 bit, downstream controller accepts the current tuple.
REQ-009 The block SHALL have ports m, r, c, n as outputs, 8 bits each, and i, j as outputs, 4 bits each: the current loop tuple.
REQ-010 The block SHALL have port valid, output, 1 bit, tuple on m..j is meaningful.
REQ-011 The block SHALL have port tap_first, output, 1 bit, high when n=0, i=0, j=0 (accumulator clear).
REQ-012 The block SHALL have port tap_last, output, 1 bit, high on the final n, i, j of a pixel (output write).
REQ-013 The block SHALL have ports busy, output, 1 bit, and done, output, 1 bit, single-cycle end-of-layer pulse.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE; reset enters IDLE.
REQ-015 IDLE->RUN SHALL occur on start=1; all counters load 0 and valid rises in the next cycle.
REQ-016 In RUN the tuple SHALL advance exactly once per cycle with valid=1 and ready=1, and SHALL hold unchanged while ready=0.
REQ-017 Loop nesting SHALL be, outermost to innermost: m, r, c, n, i, j.
REQ-018 j SHALL increment by 1 and wrap to 0 at K-1, carrying into i; i wraps at K-1 into n.
REQ-019 n SHALL increment by 4 and wrap after 4*(IN_CHANNEL-1) into c; c wraps at OUT_SIZE-1 into r; r wraps at OUT_SIZE-1 into m.
REQ-020 An accepted tuple with every counter at its maximum SHALL cause RUN->DONE; valid drops in the next cycle.
REQ-021 DONE SHALL assert done for exactly one cycle, then return to IDLE; outputs hold the last tuple.
REQ-022 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-023 start SHALL be ignored while busy=1.
REQ-024 tap_first and tap_last SHALL be combinational decodes of the registered counters, gated by valid.
REQ-025 Tuple count per layer SHALL be OUT_CHANNEL*OUT_SIZE^2*IN_CHANNEL*K^2 accepted handshakes: 117600 at defaults.

Reset
REQ-026 rst_n=0 SHALL force asynchronously: state=IDLE, m=r=c=n=i=j=0, valid=0, busy=0, done=0.
REQ-027 Reset mid-RUN SHALL abandon the layer with no done pulse; a fresh start is then required.

Structure
REQ-028 State encoding and default K, OUT_SIZE, IN_CHANNEL, OUT_CHANNEL values SHALL reside in a shared package, cnn_pkg.
REQ-029 One sub-module, wrap_counter (parameterised limit, step, enable in, carry out), SHALL be instantiated once per loop level.

Verification
REQ-030 Reset, then start pulse with ready=1 -> next cycle valid=1, tuple all 0, tap_first=1.
REQ-031 ready=1 held for 24 handshakes -> tuple i=4, j=4, tap_last=1; the next handshake gives c=1, tap_first=1.
REQ-032 ready=0 for 3 cycles mid-run -> tuple and valid held steady; it resumes from the same tuple.
REQ-033 Full run at defaults with ready=1 -> 117600 valid cycles, last tuple m=5, r=27, c=27, n=0, i=4, j=4, then one done pulse.
REQ-034 start asserted during RUN -> no counter reload; rst_n low mid-run -> outputs 0 immediately, no done.
